harness_cmd_decoder: RTL and testbench
======================================

Name: harness_cmd_decoder

Overview:
Synthesizable command front-end for running a compiled module on hardware rather than in simulation. It consumes a byte stream from the host link (UART/FIFO side) and decodes single-byte commands: dump outputs, halt, assert/deassert reset, step and load inputs. It drives the DUT's packed input bus, reset and clock enable. It serializes the DUT's packed output bus back to the host as little-endian 32-bit words.

Parameters:
INPUT_BYTES, 4, number of payload bytes following a load command; INPUT_SIZE = INPUT_BYTES*8
OUTPUT_WORDS, 1, number of 32-bit words emitted per dump; OUTPUT_SIZE = OUTPUT_WORDS*32
STEP_CYCLES, 3, cycles dut_clk_en is held high per step command (min 1)

Ports:
clk  in  1  system clock, single domain
rst  in  1  synchronous, active-high reset
in_data  in  8  host command/payload byte
in_valid  in  1  in_data valid
in_ready  out  1  block accepts in_data this cycle
out_data  out  8  response byte to host
out_valid  out  1  out_data valid
out_ready  in  1  host accepts out_data
dut_data_in  out  INPUT_SIZE  packed DUT input bus
dut_data_out  in  OUTPUT_SIZE  packed DUT output bus
dut_rst  out  1  reset to DUT
dut_clk_en  out  1  clock enable to DUT
halted  out  1  sticky; quit command or error seen
err  out  1  sticky; unknown command byte seen

Behaviour:
- Byte transfer occurs when in_valid && in_ready. Response byte transfer occurs when out_valid && out_ready. out_data is stable while out_valid && !out_ready.
- Reset values: dut_rst=1, dut_data_in=0, dut_clk_en=0, out_valid=0, out_data=0, halted=0, err=0, in_ready=1, state=IDLE, shadow and counters 0.
- States: IDLE, LOAD, STEP, DUMP, HALT. in_ready=1 in IDLE/LOAD/HALT; 0 in STEP/DUMP.
- IDLE: act on each accepted byte. Effects appear on the cycle after acceptance.
  - 0x68 dump: snapshot dut_data_out into a register on the accept edge, then go to DUMP.
  - 0x69 quit: go to HALT and set halted=1.
  - 0x6A: dut_rst=1; stay in IDLE.
  - 0x6B: dut_rst=0; stay in IDLE.
  - 0x6C step: go to STEP and load the counter with STEP_CYCLES.
  - 0x6D load: go to LOAD and clear the byte counter.
  - Any other byte: err=1, halted=1, go to HALT.
- LOAD: each accepted byte updates shadow = {byte, shadow[INPUT_SIZE-1:8]}.
  - On the INPUT_BYTES-th byte, copy the post-shift shadow to dut_data_in in the same edge, then return to IDLE.
  - The first payload byte lands in bits [7:0]. Payload bytes are never decoded as commands.
  - dut_data_in is unchanged until the commit edge; it never updates partially.
- STEP: dut_clk_en=1 for exactly STEP_CYCLES consecutive cycles starting the cycle after acceptance, then 0 and return to IDLE. dut_rst is held unchanged throughout.
- DUMP: emit OUTPUT_WORDS*4 bytes from the snapshot. Order is word 0 first, LSB byte first within each word (snapshot[7:0] first overall).
  - out_valid rises the cycle after acceptance.
  - After the last byte handshake, out_valid=0 the next cycle and the block returns to IDLE. Back-to-back transfers carry 1 byte/cycle.
  - Changes on dut_data_out after the snapshot do not affect the bytes emitted.
- HALT: in_ready=1, all bytes accepted and discarded. Outputs are frozen, dut_clk_en=0. Only rst exits.
- Synchronous rst in any state, including mid-LOAD, mid-STEP and mid-DUMP, restores all reset values on the next edge:
  - partial shadow is discarded;
  - a pending out byte is dropped;
  - dut_clk_en is forced to 0.
- Counters are sized $clog2(max+1); no wrap-around is possible within legal operation.

Decomposition:
- harness_pkg holds:
  - command constants CMD_DUMP=8'h68, CMD_QUIT=8'h69, CMD_RST_ON=8'h6A, CMD_RST_OFF=8'h6B, CMD_STEP=8'h6C, CMD_LOAD=8'h6D;
  - the state enum;
  - a WORD_BYTES=4 constant.
- One sub-module, harness_tx_serializer, holds the snapshot register, byte index and valid/ready output. Its interface is start/snapshot in, busy out.

Test Plan:
- Reset, then idle with in_valid=0 -> dut_rst=1, dut_data_in=0, dut_clk_en=0, out_valid=0, in_ready=1.
- Bytes 6B, 6D, 11, 22, 33, 44 -> dut_rst=0 the cycle after 6B. dut_data_in stays 0 through byte 33, then becomes 32'h44332211 the cycle after byte 44.
- dut_data_out=32'hDEADBEEF, send 68, change dut_data_out to 0 next cycle, out_ready toggled 1/0 -> bytes EF, BE, AD, DE in order, each held while out_ready=0, in_ready=0 until done.
- Byte 6C with STEP_CYCLES=3 -> dut_clk_en high exactly 3 cycles, in_ready low those 3 cycles, next byte accepted on the 4th.
- Byte 7F -> err=1 and halted=1. Following 6B is accepted but dut_rst stays 1. Pulse rst -> err=0, halted=0.
- 6D, AA, BB, then rst asserted -> dut_data_in=0. Following bytes 6A, 6D, 01, 02, 03, 04 -> dut_data_in=32'h04030201; the stale AA/BB bytes are not carried over.

Source files
------------

// File: rtl/harness_pkg.sv
// harness_pkg: command codes, decoder states and word geometry shared by the harness
package harness_pkg;
  localparam logic [7:0] CMD_DUMP    = 8'h68;
  localparam logic [7:0] CMD_QUIT    = 8'h69;
  localparam logic [7:0] CMD_RST_ON  = 8'h6A;
  localparam logic [7:0] CMD_RST_OFF = 8'h6B;
  localparam logic [7:0] CMD_STEP    = 8'h6C;
  localparam logic [7:0] CMD_LOAD    = 8'h6D;
  localparam int WORD_BYTES = 4;
  typedef enum logic [2:0] {IDLE, LOAD, STEP, DUMP, HALT} state_t;
endpackage

// File: rtl/harness_cmd_decoder_if.sv
// harness_cmd_decoder_if: host byte link, command stream in and response stream out
interface harness_cmd_decoder_if;
  logic [7:0] in_data;
  logic in_valid;
  logic in_ready;
  logic [7:0] out_data;
  logic out_valid;
  logic out_ready;
  modport master(output in_data, in_valid, out_ready, input in_ready, out_data, out_valid);
  modport slave(input in_data, in_valid, out_ready, output in_ready, out_data, out_valid);
endinterface

// File: rtl/harness_tx_serializer.sv
// harness_tx_serializer: snapshots the dut output bus and streams it LSB byte first
module harness_tx_serializer
  import harness_pkg::*;
#(
  parameter int OUTPUT_WORDS = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic [OUTPUT_WORDS*32-1:0] snapshot,
  output logic busy,
  output logic [7:0] out_data,
  output logic out_valid,
  input  logic out_ready
);
  localparam int NB = OUTPUT_WORDS * WORD_BYTES;
  localparam int IW = $clog2(NB + 1);
  logic [OUTPUT_WORDS*32-1:0] sr;
  logic [IW-1:0] idx;
  logic last;
  assign last = idx == IW'(NB - 1);
  assign out_data = sr[7:0];
  assign busy = out_valid && !(out_ready && last);
  always_ff @(posedge clk) begin
    if (rst) begin
      sr <= '0;
      idx <= '0;
      out_valid <= 1'b0;
    end else if (start) begin
      sr <= snapshot;
      idx <= '0;
      out_valid <= 1'b1;
    end else if (out_valid && out_ready) begin
      sr <= sr >> 8;
      idx <= idx + 1'b1;
      out_valid <= !last;
    end
  end
endmodule

// File: rtl/harness_cmd_decoder.sv
// harness_cmd_decoder: decodes host commands into dut reset, clock enable, input load and output dump
module harness_cmd_decoder
  import harness_pkg::*;
#(
  parameter int INPUT_BYTES  = 4,
  parameter int OUTPUT_WORDS = 1,
  parameter int STEP_CYCLES  = 3
) (
  input  logic clk,
  input  logic rst,
  harness_cmd_decoder_if.slave host,
  output logic [INPUT_BYTES*8-1:0] dut_data_in,
  input  logic [OUTPUT_WORDS*32-1:0] dut_data_out,
  output logic dut_rst,
  output logic dut_clk_en,
  output logic halted,
  output logic err
);
  localparam int IS = INPUT_BYTES * 8;
  localparam int BW = $clog2(INPUT_BYTES + 1);
  localparam int SW = $clog2(STEP_CYCLES + 1);
  state_t state;
  logic [IS-1:0] shadow, shadow_n;
  logic [BW-1:0] bcnt;
  logic [SW-1:0] scnt;
  logic acc, start, busy;
  assign host.in_ready = state == IDLE || state == LOAD || state == HALT;
  assign acc = host.in_valid && host.in_ready;
  assign start = acc && state == IDLE && host.in_data == CMD_DUMP;
  assign shadow_n = (shadow >> 8) | (IS'(host.in_data) << (IS - 8));
  harness_tx_serializer #(.OUTPUT_WORDS(OUTPUT_WORDS)) u_tx (
    .clk(clk),
    .rst(rst),
    .start(start),
    .snapshot(dut_data_out),
    .busy(busy),
    .out_data(host.out_data),
    .out_valid(host.out_valid),
    .out_ready(host.out_ready)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      shadow <= '0;
      bcnt <= '0;
      scnt <= '0;
      dut_data_in <= '0;
      dut_rst <= 1'b1;
      dut_clk_en <= 1'b0;
      halted <= 1'b0;
      err <= 1'b0;
    end else begin
      case (state)
        IDLE: if (acc) begin
          case (host.in_data)
            CMD_DUMP: state <= DUMP;
            CMD_QUIT: begin
              state <= HALT;
              halted <= 1'b1;
            end
            CMD_RST_ON: dut_rst <= 1'b1;
            CMD_RST_OFF: dut_rst <= 1'b0;
            CMD_STEP: begin
              state <= STEP;
              scnt <= SW'(STEP_CYCLES);
              dut_clk_en <= 1'b1;
            end
            CMD_LOAD: begin
              state <= LOAD;
              bcnt <= '0;
            end
            default: begin
              state <= HALT;
              err <= 1'b1;
              halted <= 1'b1;
            end
          endcase
        end
        LOAD: if (acc) begin
          shadow <= shadow_n;
          bcnt <= bcnt + 1'b1;
          if (bcnt == BW'(INPUT_BYTES - 1)) begin
            dut_data_in <= shadow_n;
            state <= IDLE;
          end
        end
        STEP: if (scnt == SW'(1)) begin
          dut_clk_en <= 1'b0;
          state <= IDLE;
        end else scnt <= scnt - 1'b1;
        DUMP: if (!busy) state <= IDLE;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_harness_cmd_decoder.sv
// tb_harness_cmd_decoder: directed scenarios with hand-computed expectations
module tb_harness_cmd_decoder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] dut_data_in;
  logic [31:0] dut_data_out = '0;
  logic dut_rst, dut_clk_en, halted, err;
  int checks = 0;
  int errors = 0;
  harness_cmd_decoder_if bus();
  harness_cmd_decoder #(.INPUT_BYTES(4), .OUTPUT_WORDS(1), .STEP_CYCLES(3)) dut (
    .clk(clk),
    .rst(rst),
    .host(bus.slave),
    .dut_data_in(dut_data_in),
    .dut_data_out(dut_data_out),
    .dut_rst(dut_rst),
    .dut_clk_en(dut_clk_en),
    .halted(halted),
    .err(err)
  );
  always #5 clk = ~clk;
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    bus.in_data = b;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.in_ready) begin
      checks++; errors++;
      $display("FAIL send_timeout byte=%h in_ready=%b want 1", b, bus.in_ready);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask
  task automatic pulse_rst();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask
  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (dut_rst !== 1'b1) begin errors++; $display("FAIL reset_dut_rst got %b want 1", dut_rst); end
    checks++; if (dut_data_in !== 32'h0) begin errors++; $display("FAIL reset_data_in got %h want 0", dut_data_in); end
    checks++; if (dut_clk_en !== 1'b0) begin errors++; $display("FAIL reset_clk_en got %b want 0", dut_clk_en); end
    checks++; if (bus.out_valid !== 1'b0 || bus.out_data !== 8'h00) begin errors++; $display("FAIL reset_out got v=%b d=%h want 0/00", bus.out_valid, bus.out_data); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
    checks++; if (halted !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL reset_flags got h=%b e=%b want 0/0", halted, err); end
  endtask
  task automatic test_load();
    logic [7:0] pl [3] = '{8'h11, 8'h22, 8'h33};
    send_byte(8'h6B);
    checks++; if (dut_rst !== 1'b0) begin errors++; $display("FAIL rst_off got %b want 0", dut_rst); end
    send_byte(8'h6D);
    for (int i = 0; i < 3; i++) begin
      send_byte(pl[i]);
      checks++; if (dut_data_in !== 32'h0) begin errors++; $display("FAIL load_partial%0d got %h want 0", i, dut_data_in); end
    end
    send_byte(8'h44);
    checks++; if (dut_data_in !== 32'h44332211) begin errors++; $display("FAIL load_commit got %h want 44332211", dut_data_in); end
  endtask
  task automatic test_dump();
    logic [7:0] exp [4] = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
    bus.out_ready = 1'b0;
    dut_data_out = 32'hDEADBEEF;
    send_byte(8'h68);
    dut_data_out = 32'h0;
    for (int i = 0; i < 4; i++) begin
      checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== exp[i]) begin errors++; $display("FAIL dump_byte%0d got v=%b d=%h want 1/%h", i, bus.out_valid, bus.out_data, exp[i]); end
      @(posedge clk); #1;
      checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== exp[i]) begin errors++; $display("FAIL dump_hold%0d got v=%b d=%h want 1/%h", i, bus.out_valid, bus.out_data, exp[i]); end
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL dump_in_ready%0d got %b want 0", i, bus.in_ready); end
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
    end
    checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin errors++; $display("FAIL dump_done got v=%b rdy=%b want 0/1", bus.out_valid, bus.in_ready); end
  endtask
  task automatic test_back_to_back_dump();
    logic [7:0] exp [4] = '{8'h78, 8'h56, 8'h34, 8'h12};
    dut_data_out = 32'h12345678;
    bus.out_ready = 1'b1;
    send_byte(8'h68);
    for (int i = 0; i < 4; i++) begin
      checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== exp[i]) begin errors++; $display("FAIL b2b_byte%0d got v=%b d=%h want 1/%h", i, bus.out_valid, bus.out_data, exp[i]); end
      @(posedge clk); #1;
    end
    checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin errors++; $display("FAIL b2b_done got v=%b rdy=%b want 0/1", bus.out_valid, bus.in_ready); end
    bus.out_ready = 1'b0;
  endtask
  task automatic test_step();
    send_byte(8'h6C);
    for (int i = 0; i < 3; i++) begin
      checks++; if (dut_clk_en !== 1'b1 || bus.in_ready !== 1'b0) begin errors++; $display("FAIL step_cyc%0d got en=%b rdy=%b want 1/0", i, dut_clk_en, bus.in_ready); end
      checks++; if (dut_rst !== 1'b0) begin errors++; $display("FAIL step_rst%0d got %b want 0", i, dut_rst); end
      @(posedge clk); #1;
    end
    checks++; if (dut_clk_en !== 1'b0 || bus.in_ready !== 1'b1) begin errors++; $display("FAIL step_end got en=%b rdy=%b want 0/1", dut_clk_en, bus.in_ready); end
  endtask
  task automatic test_halt();
    send_byte(8'h6A);
    checks++; if (dut_rst !== 1'b1) begin errors++; $display("FAIL rst_on got %b want 1", dut_rst); end
    send_byte(8'h7F);
    checks++; if (err !== 1'b1 || halted !== 1'b1) begin errors++; $display("FAIL bad_cmd got e=%b h=%b want 1/1", err, halted); end
    send_byte(8'h6B);
    checks++; if (dut_rst !== 1'b1 || bus.in_ready !== 1'b1) begin errors++; $display("FAIL halt_frozen got rst=%b rdy=%b want 1/1", dut_rst, bus.in_ready); end
    send_byte(8'h6C);
    checks++; if (dut_clk_en !== 1'b0) begin errors++; $display("FAIL halt_step got %b want 0", dut_clk_en); end
    pulse_rst();
    checks++; if (err !== 1'b0 || halted !== 1'b0) begin errors++; $display("FAIL halt_clear got e=%b h=%b want 0/0", err, halted); end
    send_byte(8'h69);
    checks++; if (halted !== 1'b1 || err !== 1'b0) begin errors++; $display("FAIL quit got h=%b e=%b want 1/0", halted, err); end
    pulse_rst();
  endtask
  task automatic test_rst_mid_ops();
    logic [7:0] pl [4] = '{8'h01, 8'h02, 8'h03, 8'h04};
    send_byte(8'h6B);
    send_byte(8'h6D);
    send_byte(8'hAA);
    send_byte(8'hBB);
    pulse_rst();
    checks++; if (dut_data_in !== 32'h0 || dut_rst !== 1'b1) begin errors++; $display("FAIL mid_load_rst got d=%h rst=%b want 0/1", dut_data_in, dut_rst); end
    send_byte(8'h6A);
    send_byte(8'h6D);
    for (int i = 0; i < 4; i++) send_byte(pl[i]);
    checks++; if (dut_data_in !== 32'h04030201) begin errors++; $display("FAIL reload got %h want 04030201", dut_data_in); end
    send_byte(8'h6C);
    pulse_rst();
    checks++; if (dut_clk_en !== 1'b0 || bus.in_ready !== 1'b1) begin errors++; $display("FAIL mid_step_rst got en=%b rdy=%b want 0/1", dut_clk_en, bus.in_ready); end
    send_byte(8'h68);
    pulse_rst();
    checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || dut_data_in !== 32'h0) begin errors++; $display("FAIL mid_dump_rst got v=%b rdy=%b d=%h want 0/1/0", bus.out_valid, bus.in_ready, dut_data_in); end
  endtask
  initial begin
    bus.in_data = 8'h00;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    test_reset();
    test_load();
    test_dump();
    test_back_to_back_dump();
    test_step();
    test_halt();
    test_rst_mid_ops();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
